// File: rtl/motor_dir_guard_if.sv
// Motor direction guard bus: controller-side commands in, guarded H-bridge drive out.
// master: motor controller / bench (drives *_in, observes guarded outputs)
// slave : motor_dir_guard (reads *_in, drives guarded outputs)
interface motor_dir_guard_if;
    logic       en_a_in;
    logic       en_b_in;
    logic [1:0] dir_a_in;
    logic [1:0] dir_b_in;
    logic       en_a_out;
    logic       en_b_out;
    logic [1:0] dir_a_out;
    logic [1:0] dir_b_out;
    logic       blank_a;
    logic       blank_b;
    logic [7:0] rev_count;

    modport master (
        output en_a_in, en_b_in, dir_a_in, dir_b_in,
        input  en_a_out, en_b_out, dir_a_out, dir_b_out, blank_a, blank_b, rev_count
    );

    modport slave (
        input  en_a_in, en_b_in, dir_a_in, dir_b_in,
        output en_a_out, en_b_out, dir_a_out, dir_b_out, blank_a, blank_b, rev_count
    );
endinterface

// File: rtl/motor_dir_guard.sv
// Dead-time guard for a two-channel H-bridge. Any direction change on a channel
// forces its enable low for DEAD_CYCLES cycles before the new direction is applied.
// Ports: clock, reset (sync, active-high), bus (slave modport):
//   en_x_in/dir_x_in  -> controller commands, dir 2'b11 treated as coast (00)
//   en_x_out/dir_x_out -> guarded bridge drive, blank_x high while not in RUN
//   rev_count          -> saturating count of direction-change events
module motor_dir_guard #(
    parameter int unsigned DEAD_CYCLES = 100000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic             clock,
    input  logic             reset,
    motor_dir_guard_if.slave bus
);

    localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD_CYCLES);
    localparam int unsigned      NUM_CH   = 2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BLANK  = 2'd1,
        ST_SWITCH = 2'd2
    } state_e;

    state_e           state_q   [NUM_CH];
    logic [CNT_W-1:0] cnt_q     [NUM_CH];
    logic [1:0]       dir_q     [NUM_CH];
    logic [1:0]       dir_out_q [NUM_CH];
    logic             en_out_q  [NUM_CH];
    logic             blank_q   [NUM_CH];
    logic [7:0]       rev_q;
    logic [7:0]       rev_d;

    logic             en_in     [NUM_CH];
    logic [1:0]       dir_n     [NUM_CH];
    logic [CNT_W-1:0] cnt_inc   [NUM_CH];
    logic             change    [NUM_CH];

    // 2'b11 would short the bridge leg; treat it as coast.
    function automatic logic [1:0] norm_dir(input logic [1:0] d);
        return (d == 2'b11) ? 2'b00 : d;
    endfunction

    assign en_in[0] = bus.en_a_in;
    assign en_in[1] = bus.en_b_in;
    assign dir_n[0] = norm_dir(bus.dir_a_in);
    assign dir_n[1] = norm_dir(bus.dir_b_in);

    // Per-channel helpers: next counter value and RUN->BLANK detection.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        assign cnt_inc[ch] = cnt_q[ch] + CNT_W'(1);
        assign change[ch]  = (state_q[ch] == ST_RUN) && (dir_n[ch] != dir_q[ch]);
    end

    // Saturating add of 0, 1 or 2 new reversal events.
    always_comb begin
        logic [8:0] sum;
        rev_d = rev_q;
        sum   = {1'b0, rev_q} + 9'(change[0]) + 9'(change[1]);
        rev_d = (sum > 9'd255) ? 8'hFF : sum[7:0];
    end

    // Channel FSMs and reversal counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch]   <= ST_RUN;
                cnt_q[ch]     <= '0;
                dir_q[ch]     <= 2'b00;
                dir_out_q[ch] <= 2'b00;
                en_out_q[ch]  <= 1'b0;
                blank_q[ch]   <= 1'b0;
            end
            rev_q <= 8'd0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                case (state_q[ch])
                    ST_RUN: begin
                        dir_out_q[ch] <= dir_q[ch];
                        if (change[ch]) begin
                            state_q[ch]  <= ST_BLANK;
                            en_out_q[ch] <= 1'b0;
                            cnt_q[ch]    <= CNT_W'(1);
                            blank_q[ch]  <= 1'b1;
                        end else begin
                            en_out_q[ch] <= en_in[ch];
                        end
                    end
                    ST_BLANK: begin
                        // Counter is never restarted here; only the input seen
                        // on the exit edge becomes the new direction.
                        en_out_q[ch] <= 1'b0;
                        if (cnt_inc[ch] == DEAD_CNT) begin
                            state_q[ch]   <= ST_SWITCH;
                            dir_q[ch]     <= dir_n[ch];
                            dir_out_q[ch] <= dir_n[ch];
                            cnt_q[ch]     <= '0;
                        end else begin
                            cnt_q[ch] <= cnt_inc[ch];
                        end
                    end
                    ST_SWITCH: begin
                        // Enable resumes on the edge leaving SWITCH.
                        state_q[ch]   <= ST_RUN;
                        en_out_q[ch]  <= en_in[ch];
                        dir_out_q[ch] <= dir_q[ch];
                        blank_q[ch]   <= 1'b0;
                    end
                    default: begin
                        state_q[ch]  <= ST_RUN;
                        en_out_q[ch] <= 1'b0;
                        cnt_q[ch]    <= '0;
                        blank_q[ch]  <= 1'b0;
                    end
                endcase
            end
            rev_q <= rev_d;
        end
    end

    assign bus.en_a_out  = en_out_q[0];
    assign bus.en_b_out  = en_out_q[1];
    assign bus.dir_a_out = dir_out_q[0];
    assign bus.dir_b_out = dir_out_q[1];
    assign bus.blank_a   = blank_q[0];
    assign bus.blank_b   = blank_q[1];
    assign bus.rev_count = rev_q;

endmodule

// File: tb/tb_motor_dir_guard.sv
// Directed bench for motor_dir_guard with an 8-cycle blanking window.
module tb_motor_dir_guard;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   exp_rev;

    motor_dir_guard_if bus ();

    motor_dir_guard #(.DEAD_CYCLES(8), .CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int en, input int dir, input int blank);
        chk({tag, ".en_a"},  32'(bus.en_a_out),  32'(en));
        chk({tag, ".dir_a"}, 32'(bus.dir_a_out), 32'(dir));
        chk({tag, ".blk_a"}, 32'(bus.blank_a),   32'(blank));
    endtask

    task automatic chk_b(input string tag, input int en, input int dir, input int blank);
        chk({tag, ".en_b"},  32'(bus.en_b_out),  32'(en));
        chk({tag, ".dir_b"}, 32'(bus.dir_b_out), 32'(dir));
        chk({tag, ".blk_b"}, 32'(bus.blank_b),   32'(blank));
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        bus.en_a_in = 1'b0; bus.en_b_in = 1'b0;
        bus.dir_a_in = 2'b00; bus.dir_b_in = 2'b00;
        tick(); tick();
        chk_a("rst", 0, 0, 0);
        chk_b("rst", 0, 0, 0);
        chk("rst.rev", 32'(bus.rev_count), 0);
        reset = 1'b0;

        // Steady direction: enable passes with one cycle latency
        for (int i = 0; i < 6; i++) begin
            bus.en_a_in = i[0];
            tick();
            chk_a("pass", i % 2, 0, 0);
        end
        chk("pass.rev", 32'(bus.rev_count), 0);

        // 00 -> 10 with enable high: blank edges N..N+7, new dir at N+7, enable at N+8
        bus.en_a_in = 1'b1; bus.dir_a_in = 2'b10;
        tick();
        chk_a("chg.N", 0, 0, 1);
        chk("chg.rev", 32'(bus.rev_count), 1);
        for (int k = 1; k <= 6; k++) begin
            bus.en_a_in = k[0];       // pulses during blanking must be dropped
            tick();
            chk_a("chg.blank", 0, 0, 1);
        end
        bus.en_a_in = 1'b1;
        tick();
        chk_a("chg.N7", 0, 2, 1);
        tick();
        chk_a("chg.N8", 1, 2, 0);
        chk("chg.rev8", 32'(bus.rev_count), 1);

        // Channel B 00 -> 11 is coast -> coast: no blanking
        bus.en_b_in = 1'b1; bus.dir_b_in = 2'b11;
        tick();
        chk_b("c11", 1, 0, 0);
        tick();
        chk_b("c11b", 1, 0, 0);
        chk("c11.rev", 32'(bus.rev_count), 1);

        // Channel A 10 -> 11 acts as 10 -> 00, output never shows 11
        bus.dir_a_in = 2'b11;
        tick();
        chk_a("a11.N", 0, 2, 1);
        chk("a11.rev", 32'(bus.rev_count), 2);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_a("a11.blank", 0, 2, 1);
        end
        tick();
        chk_a("a11.N7", 0, 0, 1);
        tick();
        chk_a("a11.N8", 1, 0, 0);

        // Both channels change on the same edge
        bus.dir_a_in = 2'b01; bus.dir_b_in = 2'b10;
        tick();
        chk_a("both.N", 0, 0, 1);
        chk_b("both.N", 0, 0, 1);
        chk("both.rev", 32'(bus.rev_count), 4);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("both.lock", 32'(bus.blank_a & bus.blank_b), 1);
        end
        tick();
        chk_a("both.N7", 0, 1, 1);
        chk_b("both.N7", 0, 2, 1);
        tick();
        chk_a("both.N8", 1, 1, 0);
        chk_b("both.N8", 1, 2, 0);

        // Input changes mid-blank: no restart, exit-edge value wins
        bus.dir_a_in = 2'b10;
        tick();
        chk("mid.rev", 32'(bus.rev_count), 5);
        tick(); tick(); tick();
        bus.dir_a_in = 2'b00;
        tick(); tick(); tick();
        chk_a("mid.N6", 0, 1, 1);
        tick();
        chk_a("mid.N7", 0, 0, 1);
        tick();
        chk_a("mid.N8", 1, 0, 0);
        chk("mid.rev8", 32'(bus.rev_count), 5);

        // Back-to-back reversals on both channels up to saturation
        exp_rev = 5;
        for (int i = 0; i < 150; i++) begin
            bus.dir_a_in = (i % 2 == 0) ? 2'b10 : 2'b00;
            bus.dir_b_in = (i % 2 == 0) ? 2'b00 : 2'b10;
            tick();
            exp_rev = (exp_rev + 2 > 255) ? 255 : exp_rev + 2;
            chk("sat.rev", 32'(bus.rev_count), 32'(exp_rev));
            for (int k = 1; k <= 8; k++) tick();
        end
        chk("sat.final", 32'(bus.rev_count), 255);
        chk_a("sat.run", 1, 0, 0);

        // Reset four cycles into a blank window
        bus.dir_a_in = 2'b10;
        tick(); tick(); tick(); tick();
        chk("rst2.pre", 32'(bus.blank_a), 1);
        reset = 1'b1;
        tick();
        chk_a("rst2", 0, 0, 0);
        chk_b("rst2", 0, 0, 0);
        chk("rst2.rev", 32'(bus.rev_count), 0);
        reset = 1'b0;
        bus.dir_b_in = 2'b00;
        tick();
        chk_a("rel.N", 0, 0, 1);
        chk_b("rel.N", 1, 0, 0);
        chk("rel.rev", 32'(bus.rev_count), 1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_a("rel.blank", 0, 0, 1);
        end
        tick();
        chk_a("rel.N7", 0, 2, 1);
        tick();
        chk_a("rel.N8", 1, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motor_dir_guard.md
MOTOR_DIR_GUARD -- requirements
Module: motor_dir_guard

Interface
REQ-001 Parameter DEAD_CYCLES, default 100000, is the blanking length in clock cycles (1 ms at 100 MHz); legal range 2..2^20-1.
REQ-002 Parameter CNT_W, default 20, is the blanking counter width; it SHALL satisfy 2^CNT_W > DEAD_CYCLES.
REQ-003 Port clock, input, 1 bit: single system clock, 100 MHz, rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port en_a_in, input, 1 bit: channel A PWM enable from the motor controller (enableA).
REQ-006 Port en_b_in, input, 1 bit: channel B PWM enable from the motor controller (enableB).
REQ-007 Port dir_a_in, input, 2 bits: channel A direction command {JA1,JA2}.
REQ-008 Port dir_b_in, input, 2 bits: channel B direction command {JA3,JA4}.
REQ-009 Port en_a_out / en_b_out, output, 1 bit each: guarded enables to the H-bridge.
REQ-010 Port dir_a_out / dir_b_out, output, 2 bits each: guarded direction pins to the H-bridge.
REQ-011 Port blank_a / blank_b, output, 1 bit each: high while the channel is not in RUN.
REQ-012 Port rev_count, output, 8 bits: saturating count of direction-change events, both channels combined.

Function
REQ-013 All inputs are synchronous to clock; all outputs SHALL be registered.
REQ-014 A direction input of 2'b11 SHALL be normalised to 2'b00 (coast) before any comparison or output; 2'b11 SHALL never appear on dir_*_out.
REQ-015 Each channel SHALL run an independent FSM with states RUN, BLANK and SWITCH, plus a held direction register dir_q.
REQ-016 RUN, normalised input equals dir_q: en_out <= en_in and dir_out <= dir_q, giving 1-cycle latency.
REQ-017 RUN, normalised input differs from dir_q: next state BLANK, en_out <= 0, dir_out holds the old dir_q, counter <= 1.
REQ-018 BLANK: en_out stays 0 and dir_out stays at the old value; the counter increments each cycle.
REQ-019 BLANK exit: when the counter equals DEAD_CYCLES, go to SWITCH and load dir_q and dir_out with the normalised input sampled on that edge.
REQ-020 Input changes during BLANK SHALL NOT restart the counter; only the value sampled at BLANK exit is used, even if it equals the old dir_q.
REQ-021 SWITCH: lasts exactly 1 cycle with en_out = 0, then goes to RUN.
REQ-022 If the input differs from the new dir_q on the first RUN cycle after SWITCH, a new BLANK SHALL start per REQ-017.
REQ-023 Timing: for a change sampled at edge N, en_out is 0 from edge N and dir_out changes at edge N+DEAD_CYCLES-1. en_out follows en_in again from edge N+DEAD_CYCLES.
REQ-024 blank_x SHALL be 1 in BLANK and SWITCH and 0 in RUN, registered with the state.
REQ-025 rev_count SHALL increment on each RUN->BLANK transition.
REQ-026 If both channels enter BLANK on the same edge, rev_count SHALL increase by 2.
REQ-027 rev_count SHALL saturate at 255 and SHALL NOT wrap.
REQ-028 en_in pulses during BLANK or SWITCH SHALL be dropped and never replayed.

Reset
REQ-029 With reset high at a rising edge, the block SHALL set on the next cycle: both FSMs to RUN, dir_q = 00, all en_out = 0, all dir_out = 00, blank_a = blank_b = 0, rev_count = 0, counters = 0.
REQ-030 Reset SHALL take priority over all other events, including mid-BLANK; no blanking SHALL resume after reset release.
REQ-031 On the first cycle after reset release, an input other than 00 SHALL count as a direction change and start BLANK.

Verification (DEAD_CYCLES = 8)
REQ-032 Reset, then dir_a_in = 00 and en_a_in toggling -> en_a_out equals en_a_in delayed 1 cycle; blank_a = 0; rev_count = 0.
REQ-033 dir_a_in 00->10 at edge N with en_a_in = 1 -> en_a_out = 0 for edges N..N+7; dir_a_out = 10 from edge N+7; en_a_out = 1 from edge N+8; rev_count = 1.
REQ-034 dir_a_in = 11 -> dir_a_out = 00 at all times; moving from 00 to 11 does not start BLANK.
REQ-035 Both channels change direction on the same edge -> both blank in lockstep; rev_count increases by 2.
REQ-036 dir_a_in = 10, then 01 three cycles into BLANK -> the counter does not restart; dir_a_out = 01 at the original N+7; then 300 reversals -> rev_count saturates at 255.
REQ-037 Reset asserted 4 cycles into BLANK -> all outputs 0 the next cycle; after release with dir_a_in = 10, a fresh 8-cycle BLANK starts.
